// File: rtl/lcd_encoder_burst_pkg.sv
// Shared constants, action/state encodings and instruction builders for the
// KS0108-class LCD encoder with FILL_PAGE burst.
package lcd_encoder_burst_pkg;

  localparam logic LCD_INSTRUCTION = 1'b0;
  localparam logic LCD_DATA        = 1'b1;
  localparam logic LCD_WRITE       = 1'b0;

  localparam logic [1:0] LCD_DATA_PREFIX_Y     = 2'b01;
  localparam logic [4:0] LCD_DATA_PREFIX_X     = 5'b10111;
  localparam logic [1:0] LCD_DATA_PREFIX_START = 2'b11;
  localparam logic [7:0] LCD_INSTR_DISPLAY_ON  = {7'b0011111, 1'b1};

  typedef enum logic [1:0] {
    LCD_DATA_ACTION_WRITE_DATA               = 2'd0,
    LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE = 2'd1,
    LCD_DATA_ACTION_FILL_PAGE                = 2'd2,
    LCD_DATA_ACTION_NOP                      = 2'd3
  } lcd_data_action_e;

  typedef enum logic [3:0] {
    ST_INIT_RESET,
    ST_INIT_RELEASE,
    ST_DISPLAY_ON,
    ST_IDLE,
    ST_SEND_Y,
    ST_SEND_X,
    ST_SEND_DATA,
    ST_SEND_START,
    ST_FILL,
    ST_DROP
  } lcd_enc_state_e;

  function automatic logic [7:0] lcd_instr_y(input logic [5:0] y);
    return {LCD_DATA_PREFIX_Y, y};
  endfunction

  function automatic logic [7:0] lcd_instr_x(input logic [2:0] x);
    return {LCD_DATA_PREFIX_X, x};
  endfunction

  function automatic logic [7:0] lcd_instr_start(input logic [5:0] line);
    return {LCD_DATA_PREFIX_START, line};
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One panel bus cycle: SETUP_CYC cycles of setup, EN_HIGH_CYC of lcd_en high,
// HOLD_CYC of hold; o_done marks the last hold cycle. Restartable back-to-back.
module lcd_bus_cycle #(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HIGH_CYC = 4,
  parameter int unsigned HOLD_CYC    = 2
) (
  input  logic clk_lcd,
  input  logic reset_n,
  input  logic i_start,
  output logic o_en,
  output logic o_done
);

  localparam int unsigned TOTAL = SETUP_CYC + EN_HIGH_CYC + HOLD_CYC;
  localparam int unsigned CNTW  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic            r_active;
  logic [CNTW-1:0] r_cnt;
  logic            r_en;
  logic            w_active_nx;
  logic [CNTW-1:0] w_cnt_nx;

  always_comb begin
    w_active_nx = r_active;
    w_cnt_nx    = r_cnt;
    if (i_start) begin
      w_active_nx = 1'b1;
      w_cnt_nx    = '0;
    end else if (r_active) begin
      if (r_cnt == CNTW'(TOTAL - 1)) w_active_nx = 1'b0;
      else                           w_cnt_nx    = r_cnt + CNTW'(1);
    end
  end

  // lcd_en is registered from the next count so the strobe never glitches
  always_ff @(posedge clk_lcd) begin
    if (!reset_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_en     <= 1'b0;
    end else begin
      r_active <= w_active_nx;
      r_cnt    <= w_cnt_nx;
      r_en     <= w_active_nx && (w_cnt_nx >= CNTW'(SETUP_CYC))
                  && (w_cnt_nx < CNTW'(SETUP_CYC + EN_HIGH_CYC));
    end
  end

  assign o_en   = r_en;
  assign o_done = r_active && (r_cnt == CNTW'(TOTAL - 1));

endmodule

// File: rtl/lcd_encoder_burst.sv
// KS0108-class LCD encoder: power-up sequence, chip routing, FILL_PAGE burst.
// Define LCD_ENC_ADDR_CACHE_EN to skip Y/X instructions that match the per-chip cache.
module lcd_encoder_burst
  import lcd_encoder_burst_pkg::*;
#(
  parameter int unsigned CS_COUNT    = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned EN_HIGH_CYC = 4,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned RESET_CYC   = 16
) (
  input  logic                            clk_lcd,
  input  logic                            reset_n,
  output logic [DATA_WIDTH-1:0]           lcd_data,
  output logic [CS_COUNT-1:0]             lcd_cs,
  output logic                            lcd_io,
  output logic                            lcd_wr,
  output logic                            lcd_en,
  output logic                            lcd_reset_n,
  output logic                            instr_busy,
  input  logic [DATA_WIDTH-1:0]           data_write,
  input  logic [5:0]                      start_line_write,
  input  logic [$clog2(64*CS_COUNT)-1:0]  addr_y,
  input  logic [2:0]                      addr_x,
  input  logic [1:0]                      data_action,
  input  logic                            data_busy
);

  localparam int unsigned YW  = $clog2(64 * CS_COUNT);
  localparam int unsigned CW  = (CS_COUNT > 1) ? $clog2(CS_COUNT) : 1;
  localparam int unsigned RCW = (RESET_CYC > 1) ? $clog2(RESET_CYC) : 1;

  lcd_enc_state_e        r_state, w_next;
  logic [RCW-1:0]        r_init_cnt;
  logic                  w_launch;
  logic                  w_accept;
  logic                  w_bus_done;
  logic                  w_bus_en;

  logic [DATA_WIDTH-1:0] r_lcd_data, w_bus_data;
  logic [CS_COUNT-1:0]   r_lcd_cs, w_bus_cs;
  logic                  r_lcd_io, w_bus_io;

  logic [YW-1:0]         r_req_y;
  logic [2:0]            r_req_x;
  logic [DATA_WIDTH-1:0] r_req_d;
  logic [5:0]            r_req_start;
  logic                  r_req_fill;
  logic [5:0]            r_fill_col;

  logic                  w_idle;
  logic [YW-1:0]         w_cur_y;
  logic [2:0]            w_cur_x;
  logic [DATA_WIDTH-1:0] w_cur_d;
  logic [5:0]            w_cur_start;
  logic                  w_cur_fill;
  logic [CW-1:0]         w_chip;
  logic [CS_COUNT-1:0]   w_onehot;
  logic                  w_y_oor;
  logic                  w_need_y, w_need_x;

  // In IDLE the request comes straight from the inputs; afterwards from the latch
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle && !data_busy;
  assign w_cur_y     = w_idle ? addr_y           : r_req_y;
  assign w_cur_x     = w_idle ? addr_x           : r_req_x;
  assign w_cur_d     = w_idle ? data_write       : r_req_d;
  assign w_cur_start = w_idle ? start_line_write : r_req_start;
  assign w_cur_fill  = w_idle ? (lcd_data_action_e'(data_action) == LCD_DATA_ACTION_FILL_PAGE)
                              : r_req_fill;
  assign w_chip      = CW'(w_cur_y >> 6);
  assign w_onehot    = CS_COUNT'(1) << w_chip;
  assign w_y_oor     = (32'(addr_y) >= 64 * CS_COUNT);

`ifdef LCD_ENC_ADDR_CACHE_EN
  logic [5:0]          r_cache_y [CS_COUNT];
  logic [2:0]          r_cache_x [CS_COUNT];
  logic [CS_COUNT-1:0] r_vy, r_vx;

  assign w_need_y = !r_vy[w_chip] || (r_cache_y[w_chip] != w_cur_y[5:0]);
  assign w_need_x = !r_vx[w_chip] || (r_cache_x[w_chip] != w_cur_x);

  always_ff @(posedge clk_lcd) begin
    if (!reset_n) begin
      r_vy <= '0;
      r_vx <= '0;
    end else if (w_bus_done) begin
      if (r_state == ST_SEND_Y && !r_req_fill) begin
        r_cache_y[w_chip] <= r_req_y[5:0];
        r_vy[w_chip]      <= 1'b1;
      end
      if (r_state == ST_SEND_X && !r_req_fill) begin
        r_cache_x[w_chip] <= r_req_x;
        r_vx[w_chip]      <= 1'b1;
      end
      // panel auto-increments Y after each data write, wrapping at 64
      if (r_state == ST_SEND_DATA) begin
        r_cache_y[w_chip] <= r_req_y[5:0] + 6'd1;
        r_vy[w_chip]      <= 1'b1;
      end
      if (r_state == ST_FILL && r_fill_col == 6'd63) begin
        for (int unsigned i = 0; i < CS_COUNT; i++) begin
          r_cache_y[i] <= '0;
          r_cache_x[i] <= r_req_x;
        end
        r_vy <= '1;
        r_vx <= '1;
      end
    end
  end
`else
  assign w_need_y = 1'b1;
  assign w_need_x = 1'b1;
`endif

  always_ff @(posedge clk_lcd) begin
    if (!reset_n) begin
      r_state     <= ST_INIT_RESET;
      r_init_cnt  <= '0;
      r_lcd_data  <= '0;
      r_lcd_cs    <= '1;
      r_lcd_io    <= LCD_INSTRUCTION;
      r_req_y     <= '0;
      r_req_x     <= '0;
      r_req_d     <= '0;
      r_req_start <= '0;
      r_req_fill  <= 1'b0;
      r_fill_col  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_init_cnt <= '0;
      else if (r_state == ST_INIT_RESET || r_state == ST_INIT_RELEASE)
        r_init_cnt <= r_init_cnt + RCW'(1);
      if (w_launch) begin
        r_lcd_data <= w_bus_data;
        r_lcd_cs   <= w_bus_cs;
        r_lcd_io   <= w_bus_io;
      end
      if (w_accept) begin
        r_req_y     <= addr_y;
        r_req_x     <= addr_x;
        r_req_d     <= data_write;
        r_req_start <= start_line_write;
        r_req_fill  <= w_cur_fill;
        r_fill_col  <= '0;
      end
      if (r_state == ST_FILL && w_bus_done) r_fill_col <= r_fill_col + 6'd1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    case (r_state)
      ST_INIT_RESET:
        if (r_init_cnt == RCW'(RESET_CYC - 1)) w_next = ST_INIT_RELEASE;
      ST_INIT_RELEASE:
        if (r_init_cnt == RCW'(RESET_CYC - 1)) begin
          w_next   = ST_DISPLAY_ON;
          w_launch = 1'b1;
        end
      ST_DISPLAY_ON:
        if (w_bus_done) w_next = ST_IDLE;
      ST_IDLE:
        if (!data_busy) begin
          case (lcd_data_action_e'(data_action))
            LCD_DATA_ACTION_WRITE_DATA:
              if (w_y_oor) w_next = ST_DROP;
              else begin
                w_launch = 1'b1;
                if (w_need_y)      w_next = ST_SEND_Y;
                else if (w_need_x) w_next = ST_SEND_X;
                else               w_next = ST_SEND_DATA;
              end
            LCD_DATA_ACTION_WRITE_DISPLAY_START_LINE: begin
              w_next   = ST_SEND_START;
              w_launch = 1'b1;
            end
            LCD_DATA_ACTION_FILL_PAGE: begin
              w_next   = ST_SEND_X;
              w_launch = 1'b1;
            end
            default: w_next = ST_DROP;
          endcase
        end
      ST_SEND_Y:
        if (w_bus_done) begin
          w_launch = 1'b1;
          if (r_req_fill)    w_next = ST_FILL;
          else if (w_need_x) w_next = ST_SEND_X;
          else               w_next = ST_SEND_DATA;
        end
      ST_SEND_X:
        if (w_bus_done) begin
          w_launch = 1'b1;
          w_next   = r_req_fill ? ST_SEND_Y : ST_SEND_DATA;
        end
      ST_SEND_DATA, ST_SEND_START:
        if (w_bus_done) w_next = ST_IDLE;
      ST_FILL:
        if (w_bus_done) begin
          if (r_fill_col == 6'd63) w_next = ST_IDLE;
          else                     w_launch = 1'b1;
        end
      ST_DROP:
        w_next = ST_IDLE;
      default:
        w_next = ST_INIT_RESET;
    endcase
  end

  // Bus content for the cycle being launched is chosen by the state it enters
  always_comb begin
    w_bus_data  = r_lcd_data;
    w_bus_cs    = r_lcd_cs;
    w_bus_io    = r_lcd_io;
    instr_busy  = (r_state != ST_IDLE);
    lcd_reset_n = (r_state != ST_INIT_RESET);
    case (w_next)
      ST_DISPLAY_ON: begin
        w_bus_data = DATA_WIDTH'(LCD_INSTR_DISPLAY_ON);
        w_bus_cs   = '1;
        w_bus_io   = LCD_INSTRUCTION;
      end
      ST_SEND_Y: begin
        w_bus_data = DATA_WIDTH'(lcd_instr_y(w_cur_fill ? 6'd0 : w_cur_y[5:0]));
        w_bus_cs   = w_cur_fill ? '1 : w_onehot;
        w_bus_io   = LCD_INSTRUCTION;
      end
      ST_SEND_X: begin
        w_bus_data = DATA_WIDTH'(lcd_instr_x(w_cur_x));
        w_bus_cs   = w_cur_fill ? '1 : w_onehot;
        w_bus_io   = LCD_INSTRUCTION;
      end
      ST_SEND_DATA: begin
        w_bus_data = w_cur_d;
        w_bus_cs   = w_onehot;
        w_bus_io   = LCD_DATA;
      end
      ST_SEND_START: begin
        w_bus_data = DATA_WIDTH'(lcd_instr_start(w_cur_start));
        w_bus_cs   = '1;
        w_bus_io   = LCD_INSTRUCTION;
      end
      ST_FILL: begin
        w_bus_data = w_cur_d;
        w_bus_cs   = '1;
        w_bus_io   = LCD_DATA;
      end
      default: ;
    endcase
  end

  lcd_bus_cycle #(
    .SETUP_CYC  (SETUP_CYC),
    .EN_HIGH_CYC(EN_HIGH_CYC),
    .HOLD_CYC   (HOLD_CYC)
  ) u_bus_cycle (
    .clk_lcd(clk_lcd),
    .reset_n(reset_n),
    .i_start(w_launch),
    .o_en   (w_bus_en),
    .o_done (w_bus_done)
  );

  assign lcd_data = r_lcd_data;
  assign lcd_cs   = r_lcd_cs;
  assign lcd_io   = r_lcd_io;
  assign lcd_wr   = LCD_WRITE;
  assign lcd_en   = w_bus_en;

endmodule
